// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor. A CHUNK-bit adder is reused
// over NCHUNK = WIDTH/CHUNK cycles, LSB chunk first, with the carry held in
// a register between chunks.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, cin, sub)
//   out_valid/out_ready result handshake (sum, cout, ovf)
//   sum                 a+b+cin or a-b-cin, modulo 2^WIDTH
//   cout                raw carry out of the MSB (subtract: 1 = no borrow)
//   ovf                 two's-complement signed overflow
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Valid, once raised, stays high with stable data until that edge.
// in_ready and out_valid are never 1 together.
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("seq_addsub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              rdy_q, rdy_d;

    logic [CHUNK-1:0]       chunk_a;
    logic [CHUNK-1:0]       chunk_b;
    logic [CHUNK:0]         chunk_res;
    logic                   msb_cin;
    logic [WIDTH+CHUNK-1:0] sum_shift;
    logic                   last_chunk;

    // Operands are shifted right each RUN cycle so the current chunk is
    // always in the low CHUNK bits; the result is shifted in from the top
    // so that after NCHUNK cycles chunk i sits at sum[i*CHUNK +: CHUNK].
    always_comb begin
        chunk_a    = op_a_q[CHUNK-1:0];
        chunk_b    = op_b_q[CHUNK-1:0];
        chunk_res  = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit of this chunk, recovered from its sum bit.
        msb_cin    = chunk_res[CHUNK-1] ^ chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1];
        sum_shift  = {chunk_res[CHUNK-1:0], sum_q};
        last_chunk = (idx_q == IDXW'(NCHUNK - 1));
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid && rdy_q) begin
                    // Subtraction is a + ~b + ~cin.
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                op_a_d  = op_a_q >> CHUNK;
                op_b_d  = op_b_q >> CHUNK;
                carry_d = chunk_res[CHUNK];
                sum_d   = sum_shift[WIDTH+CHUNK-1:CHUNK];
                idx_d   = idx_q + IDXW'(1);
                if (last_chunk) begin
                    cout_d  = chunk_res[CHUNK];
                    ovf_d   = msb_cin ^ chunk_res[CHUNK];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered so in_ready is low throughout reset and rises on the
        // first edge after release.
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: three instances (CHUNK = 1, 4, 16; WIDTH = 16) share
// clock, reset and operand buses; each has its own handshake signals.
// Index 1 (CHUNK=4) carries the directed tests.
module tb_seq_addsub;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic cin = 1'b0;
    logic sub = 1'b0;

    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [W-1:0] sum_o     [3];
    logic         cout_o    [3];
    logic         ovf_o     [3];

    logic [W+1:0] exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(W), .CHUNK(1)) u_dut_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0])
    );
    seq_addsub #(.WIDTH(W), .CHUNK(4)) u_dut_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1])
    );
    seq_addsub #(.WIDTH(W), .CHUNK(16)) u_dut_c16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .sum(sum_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2])
    );

    // Reference model built on integer arithmetic: {cout, ovf, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        int ua, ub, sa, sb, r, sr;
        logic co, ov;
        logic [W-1:0] res;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (!msub) begin
            r  = ua + ub + int'(mcin);
            co = (r >= 65536);
            sr = sa + sb + int'(mcin);
        end else begin
            r  = ua - ub - int'(mcin);
            co = (r >= 0);
            sr = sa - sb - int'(mcin);
        end
        res = r[W-1:0];
        ov  = (sr > 32767) || (sr < -32768);
        return {co, ov, res};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_op(input int k, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tcin, input logic tsub, output bit ok);
        int budget;
        ok = 1'b0;
        @(negedge clk);
        a = ta; b = tb; cin = tcin; sub = tsub;
        in_valid[k] = 1'b1;
        budget = 0;
        while (!in_ready[k] && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (in_ready[k]) begin
            ok = 1'b1;
            @(posedge clk);
        end
        #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_result(input int k, output logic [W+1:0] res, output bit ok);
        ok  = 1'b0;
        res = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid[k]) begin
                res = {cout_o[k], ovf_o[k], sum_o[k]};
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_result(input int k);
        @(negedge clk);
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[k] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({in_ready[k], out_valid[k], cout_o[k], ovf_o[k], sum_o[k]} !== '0) begin
                n_err++;
                $display("FAIL reset_values dut%0d: got rdy=%b ov=%b cout=%b ovf=%b sum=%h, want all 0",
                         k, in_ready[k], out_valid[k], cout_o[k], ovf_o[k], sum_o[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (in_ready[k] !== 1'b1) begin
                n_err++;
                $display("FAIL reset_release_ready dut%0d: got %b want 1", k, in_ready[k]);
            end
        end
    endtask

    task automatic test_basic();
        logic [W+1:0] got, exp;
        bit ok;
        exp_q.push_back({1'b0, 1'b0, 16'h5555});
        send_op(1, 16'h1234, 16'h4321, 1'b0, 1'b0, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL basic_accept: got no accept want accept"); end
        // Accept edge is E; out_valid must be low after E+1..E+3, high after E+4.
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid[1] !== (i == 4)) begin
                n_err++;
                $display("FAIL basic_latency edge E+%0d: got out_valid=%b want %b", i, out_valid[1], (i == 4));
            end
        end
        wait_result(1, got, ok);
        exp = exp_q.pop_front();
        n_cmp++;
        if (!ok || got !== exp) begin
            n_err++;
            $display("FAIL basic_result: got %h (ok=%b) want %h", got, ok, exp);
        end
        release_result(1);
    endtask

    task automatic test_carry_chain();
        logic [W+1:0] got, exp;
        bit ok, sent;
        exp_q.push_back({1'b1, 1'b0, 16'h0000});
        send_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, sent);
        wait_result(1, got, ok);
        exp = exp_q.pop_front();
        n_cmp++;
        if (!sent || !ok || got !== exp) begin
            n_err++;
            $display("FAIL carry_chain: got %h want %h", got, exp);
        end
        release_result(1);
    endtask

    task automatic test_overflow();
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        logic         tc [3];
        logic         ts [3];
        logic [W+1:0] te [3];
        logic [W+1:0] got, exp;
        bit ok, sent;
        ta[0] = 16'h7FFF; tb[0] = 16'h0001; tc[0] = 1'b0; ts[0] = 1'b0; te[0] = {1'b0, 1'b1, 16'h8000};
        ta[1] = 16'h8000; tb[1] = 16'h0001; tc[1] = 1'b0; ts[1] = 1'b1; te[1] = {1'b1, 1'b1, 16'h7FFF};
        ta[2] = 16'h0005; tb[2] = 16'h0003; tc[2] = 1'b1; ts[2] = 1'b1; te[2] = {1'b1, 1'b0, 16'h0001};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(te[i]);
            send_op(1, ta[i], tb[i], tc[i], ts[i], sent);
            wait_result(1, got, ok);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!sent || !ok || got !== exp) begin
                n_err++;
                $display("FAIL overflow_case%0d: got %h want %h", i, got, exp);
            end
            release_result(1);
        end
    endtask

    task automatic test_done_stall();
        logic [W+1:0] got, exp;
        bit ok, sent;
        exp_q.push_back({1'b0, 1'b0, 16'hEEEF});
        send_op(1, 16'h1111, 16'h2222, 1'b0, 1'b1, sent);
        wait_result(1, got, ok);
        exp = exp_q.pop_front();
        n_cmp++;
        if (!sent || !ok || got !== exp) begin
            n_err++;
            $display("FAIL stall_result: got %h want %h", got, exp);
        end
        // Offer a new operation while the result is held; it must be refused.
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0;
        in_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid[1] !== 1'b1 || in_ready[1] !== 1'b0 ||
                {cout_o[1], ovf_o[1], sum_o[1]} !== exp) begin
                n_err++;
                $display("FAIL stall_hold cycle%0d: got ov=%b rdy=%b res=%h want ov=1 rdy=0 res=%h",
                         i, out_valid[1], in_ready[1], {cout_o[1], ovf_o[1], sum_o[1]}, exp);
            end
        end
        @(negedge clk);
        in_valid[1] = 1'b0;
        release_result(1);
        n_cmp++;
        if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: got ov=%b rdy=%b want ov=0 rdy=1", out_valid[1], in_ready[1]);
        end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid[1] !== 1'b0) begin
            n_err++;
            $display("FAIL stall_no_accept: got out_valid=%b want 0", out_valid[1]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W+1:0] got, exp;
        bit ok, sent, seen;
        send_op(1, 16'h0F0F, 16'h1234, 1'b0, 1'b0, sent);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_in_reset: got ov=%b rdy=%b want 0 0", out_valid[1], in_ready[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready[1] !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_ready: got %b want 1", in_ready[1]);
        end
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid[1] !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL midrst_no_result: got out_valid=1 want 0");
        end
        exp_q.push_back({1'b0, 1'b0, 16'h1000});
        send_op(1, 16'h00FF, 16'h0F01, 1'b0, 1'b0, sent);
        wait_result(1, got, ok);
        exp = exp_q.pop_front();
        n_cmp++;
        if (!sent || !ok || got !== exp) begin
            n_err++;
            $display("FAIL midrst_next_op: got %h want %h", got, exp);
        end
        release_result(1);
    endtask

    task automatic test_random(input int k, input int n);
        int got_n;
        got_n = 0;
        exp_q.delete();
        fork
            begin : drv
                int budget;
                logic [W-1:0] ra, rb;
                logic rc, rs;
                for (int i = 0; i < n; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    @(negedge clk);
                    ra = W'($urandom); rb = W'($urandom);
                    rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
                    a = ra; b = rb; cin = rc; sub = rs;
                    in_valid[k] = 1'b1;
                    budget = 0;
                    while (!in_ready[k] && budget < 200) begin
                        @(negedge clk);
                        budget++;
                    end
                    if (in_ready[k]) begin
                        exp_q.push_back(model(ra, rb, rc, rs));
                        @(posedge clk);
                    end
                    #1;
                    in_valid[k] = 1'b0;
                    // Operand changes during RUN must not matter.
                    a = W'($urandom); b = W'($urandom);
                    cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                end
            end
            begin : mon
                int cyc;
                logic [W+1:0] obs, exp;
                cyc = 0;
                while (got_n < n && cyc < n * 80) begin
                    @(negedge clk);
                    cyc++;
                    out_ready[k] = ($urandom_range(0, 3) != 0);
                    if (out_valid[k] && out_ready[k]) begin
                        obs = {cout_o[k], ovf_o[k], sum_o[k]};
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL random_dut%0d_extra: got result %h want none", k, obs);
                        end else begin
                            exp = exp_q.pop_front();
                            if (obs !== exp) begin
                                n_err++;
                                $display("FAIL random_dut%0d #%0d: got %h want %h", k, got_n, obs, exp);
                            end
                        end
                        got_n++;
                    end
                end
                @(negedge clk);
                out_ready[k] = 1'b0;
            end
        join
        n_cmp++;
        if (got_n != n || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL random_dut%0d_count: got %0d results (%0d pending) want %0d",
                     k, got_n, exp_q.size(), n);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
        end
        test_reset();
        test_basic();
        test_carry_chain();
        test_overflow();
        test_done_stall();
        test_reset_mid_run();
        test_random(0, 1000);
        test_random(1, 1000);
        test_random(2, 1000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
